mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 113 +++++++++++
 tb/tb_mem_port_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between instruction fetch and data access.
// Data is preferred, but fetch wins right after a data grant so neither side starves.
module mem_port_arbiter #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_ready,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        stall_f,
    output logic        stall_m
);
    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC_D = 2'd1,
        ACC_F = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] waitCnt;
    logic       lastGrantData;
    logic       dataEligible;
    logic       fetchEligible;
    logic       grantData;
    logic       grantFetch;

    // A port showing ready is still holding req for the access that just finished
    always_comb begin
        dataEligible  = dm_req && !dm_ready;
        fetchEligible = if_req && !if_ready;
        grantFetch    = fetchEligible && (!dataEligible || lastGrantData);
        grantData     = dataEligible && !grantFetch;
    end

    assign stall_f = if_req & ~if_ready;
    assign stall_m = dm_req & ~dm_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            waitCnt       <= 4'd0;
            lastGrantData <= 1'b0;
            mem_en        <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= 32'd0;
            mem_wdata     <= 32'd0;
            if_ready      <= 1'b0;
            dm_ready      <= 1'b0;
            if_rdata      <= 32'd0;
            dm_rdata      <= 32'd0;
        end else if (enable) begin
            if_ready <= 1'b0;
            dm_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (grantData) begin
                        state         <= ACC_D;
                        waitCnt       <= 4'd0;
                        lastGrantData <= 1'b1;
                        mem_en        <= 1'b1;
                        mem_we        <= dm_we;
                        mem_addr      <= dm_addr;
                        mem_wdata     <= dm_wdata;
                    end else if (grantFetch) begin
                        state         <= ACC_F;
                        waitCnt       <= 4'd0;
                        lastGrantData <= 1'b0;
                        mem_en        <= 1'b1;
                        mem_we        <= 1'b0;
                        mem_addr      <= if_addr;
                        mem_wdata     <= 32'd0;
                    end
                end
                ACC_D, ACC_F: begin
                    // Memory data is valid on the last strobe cycle; completion is seen one cycle later
                    if (waitCnt == LAST_CNT) begin
                        state  <= IDLE;
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        if (state == ACC_D) begin
                            dm_ready <= 1'b1;
                            if (!mem_we) begin
                                dm_rdata <= mem_rdata;
                            end
                        end else begin
                            if_ready <= 1'b1;
                            if_rdata <= mem_rdata;
                        end
                    end else begin
                        waitCnt <= waitCnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, multi-cycle corner sequences,
// and randomized requesters checked against a transaction-level model.
module tb_mem_port_arbiter;
    localparam int W = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_addr = 32'd0;
    logic [31:0] dm_wdata = 32'd0;
    logic [31:0] mem_rdata;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic        if_ready, dm_ready, mem_en, mem_we, stall_f, stall_m;

    mem_port_arbiter #(.WAIT_CYCLES(W)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall_f(stall_f), .stall_m(stall_m)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memData(input logic [31:0] a);
        return (a == 32'h40) ? 32'h8C010004 : ~a;
    endfunction

    assign mem_rdata = memData(mem_addr);

    int nCompared = 0;
    int nMismatch = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatch++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Transaction-level model: an access granted on enabled edge k completes on enabled edge k+W
    bit          mBusy, mPortData, mWe, mLastData, mIfReady, mDmReady;
    logic [31:0] mAddr, mWdata, mIfRdata, mDmRdata;
    int          ecnt = 0;
    int          mDoneAt = 0;

    task automatic modelReset();
        mBusy = 1'b0; mPortData = 1'b0; mWe = 1'b0; mLastData = 1'b0;
        mIfReady = 1'b0; mDmReady = 1'b0;
        mAddr = 32'd0; mWdata = 32'd0; mIfRdata = 32'd0; mDmRdata = 32'd0;
    endtask

    task automatic modelStep();
        bit ifEl, dmEl;
        if (!reset) begin
            modelReset();
            return;
        end
        if (!enable) return;
        ecnt++;
        ifEl = if_req && !mIfReady;
        dmEl = dm_req && !mDmReady;
        mIfReady = 1'b0;
        mDmReady = 1'b0;
        if (mBusy) begin
            if (ecnt == mDoneAt) begin
                mBusy = 1'b0;
                if (mPortData) begin
                    mDmReady = 1'b1;
                    if (!mWe) mDmRdata = memData(mAddr);
                end else begin
                    mIfReady = 1'b1;
                    mIfRdata = memData(mAddr);
                end
            end
        end else if (dmEl && !(mLastData && ifEl)) begin
            mBusy = 1'b1; mPortData = 1'b1; mLastData = 1'b1;
            mAddr = dm_addr; mWe = dm_we; mWdata = dm_wdata;
            mDoneAt = ecnt + W;
        end else if (ifEl) begin
            mBusy = 1'b1; mPortData = 1'b0; mLastData = 1'b0;
            mAddr = if_addr; mWe = 1'b0; mWdata = 32'd0;
            mDoneAt = ecnt + W;
        end
    endtask

    task automatic checkModel(input string tag);
        chk({tag, ".if_ready"}, 32'(if_ready), 32'(mIfReady));
        chk({tag, ".dm_ready"}, 32'(dm_ready), 32'(mDmReady));
        chk({tag, ".if_rdata"}, if_rdata, mIfRdata);
        chk({tag, ".dm_rdata"}, dm_rdata, mDmRdata);
        chk({tag, ".mem_en"}, 32'(mem_en), 32'(mBusy));
        chk({tag, ".mem_we"}, 32'(mem_we), 32'(mBusy && mWe));
        if (mBusy) chk({tag, ".mem_addr"}, mem_addr, mAddr);
        if (mBusy && mWe) chk({tag, ".mem_wdata"}, mem_wdata, mWdata);
        chk({tag, ".stall_f"}, 32'(stall_f), 32'(if_req && !mIfReady));
        chk({tag, ".stall_m"}, 32'(stall_m), 32'(dm_req && !mDmReady));
    endtask

    task automatic setIn(input logic en, input logic ifr, input logic [31:0] ifa,
                         input logic dmr, input logic dmw, input logic [31:0] dma,
                         input logic [31:0] dmd);
        enable = en; if_req = ifr; if_addr = ifa;
        dm_req = dmr; dm_we = dmw; dm_addr = dma; dm_wdata = dmd;
    endtask

    task automatic tick();
        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b0;
        setIn(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        modelReset();
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset.mem_en", 32'(mem_en), 32'd0);
        chk("reset.mem_we", 32'(mem_we), 32'd0);
        chk("reset.mem_addr", mem_addr, 32'd0);
        chk("reset.mem_wdata", mem_wdata, 32'd0);
        chk("reset.if_ready", 32'(if_ready), 32'd0);
        chk("reset.dm_ready", 32'(dm_ready), 32'd0);
        chk("reset.if_rdata", if_rdata, 32'd0);
        chk("reset.dm_rdata", dm_rdata, 32'd0);
        reset = 1'b1;
    endtask

    typedef struct {
        bit          rst;
        bit          en;
        bit          ifReq;
        logic [31:0] ifAddr;
        bit          dmReq;
        bit          dmWe;
        logic [31:0] dmAddr;
        logic [31:0] dmWdata;
        bit          eMemEn;
        bit          eMemWe;
        logic [31:0] eMemAddr;
        bit          eIfRdy;
        bit          eDmRdy;
        logic [31:0] eIfRdata;
        logic [31:0] eDmRdata;
        bit          eStallF;
        bit          eStallM;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] grants[$];
    logic [31:0] fairExp[4];
    bit          ifPend = 1'b0;
    bit          dmPend = 1'b0;
    logic [31:0] ifA = 32'd0;
    logic [31:0] dmA = 32'd0;
    logic [31:0] dmD = 32'd0;
    logic        dmWeV = 1'b0;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", nCompared);
        $fatal(1, "watchdog");
    end

    initial begin
        // Row i: inputs held for one cycle; expectations are the outputs seen after that cycle's edge
        // Fetch-only read of 0x40, with req held through the ready cycle
        tbl.push_back(vec_t'{1'b1, 1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0,
                             1'b1, 1'b0, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0});
        tbl.push_back(vec_t'{1'b0, 1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0,
                             1'b1, 1'b0, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0});
        tbl.push_back(vec_t'{1'b0, 1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0,
                             1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h8C010004, 32'h0, 1'b0, 1'b0});
        tbl.push_back(vec_t'{1'b0, 1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0,
                             1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h8C010004, 32'h0, 1'b1, 1'b0});
        tbl.push_back(vec_t'{1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                             1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h8C010004, 32'h0, 1'b0, 1'b0});
        // Simultaneous requests out of reset: data write first, then fetch
        tbl.push_back(vec_t'{1'b1, 1'b1, 1'b1, 32'h80, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF,
                             1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1});
        tbl.push_back(vec_t'{1'b0, 1'b1, 1'b1, 32'h80, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF,
                             1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1});
        tbl.push_back(vec_t'{1'b0, 1'b1, 1'b1, 32'h80, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF,
                             1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b1, 1'b0});
        tbl.push_back(vec_t'{1'b0, 1'b1, 1'b1, 32'h80, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF,
                             1'b1, 1'b0, 32'h80, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1});
        tbl.push_back(vec_t'{1'b0, 1'b1, 1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 32'h0,
                             1'b1, 1'b0, 32'h80, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0});
        tbl.push_back(vec_t'{1'b0, 1'b1, 1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 32'h0,
                             1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'hFFFFFF7F, 32'h0, 1'b0, 1'b0});
        tbl.push_back(vec_t'{1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                             1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'hFFFFFF7F, 32'h0, 1'b0, 1'b0});

        foreach (tbl[i]) begin
            if (tbl[i].rst) doReset();
            setIn(tbl[i].en, tbl[i].ifReq, tbl[i].ifAddr, tbl[i].dmReq, tbl[i].dmWe,
                  tbl[i].dmAddr, tbl[i].dmWdata);
            tick();
            chk($sformatf("vec%0d.mem_en", i), 32'(mem_en), 32'(tbl[i].eMemEn));
            chk($sformatf("vec%0d.mem_we", i), 32'(mem_we), 32'(tbl[i].eMemWe));
            if (tbl[i].eMemEn) chk($sformatf("vec%0d.mem_addr", i), mem_addr, tbl[i].eMemAddr);
            if (tbl[i].eMemWe) chk($sformatf("vec%0d.mem_wdata", i), mem_wdata, tbl[i].dmWdata);
            chk($sformatf("vec%0d.if_ready", i), 32'(if_ready), 32'(tbl[i].eIfRdy));
            chk($sformatf("vec%0d.dm_ready", i), 32'(dm_ready), 32'(tbl[i].eDmRdy));
            chk($sformatf("vec%0d.if_rdata", i), if_rdata, tbl[i].eIfRdata);
            chk($sformatf("vec%0d.dm_rdata", i), dm_rdata, tbl[i].eDmRdata);
            chk($sformatf("vec%0d.stall_f", i), 32'(stall_f), 32'(tbl[i].eStallF));
            chk($sformatf("vec%0d.stall_m", i), 32'(stall_m), 32'(tbl[i].eStallM));
        end

        // Both ports held continuously: grants must alternate D, F, D, F
        doReset();
        setIn(1'b1, 1'b1, 32'h300, 1'b1, 1'b0, 32'h200, 32'h0);
        fairExp = '{32'h200, 32'h300, 32'h200, 32'h300};
        begin
            bit prevEn = 1'b0;
            for (int c = 0; c < 20 && grants.size() < 4; c++) begin
                tick();
                if (mem_en && !prevEn) grants.push_back(mem_addr);
                prevEn = mem_en;
            end
        end
        chk("fair.grantCount", 32'(grants.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < grants.size()) chk($sformatf("fair.grant%0d", i), grants[i], fairExp[i]);
        end

        // After a data grant, a fresh simultaneous request goes to fetch
        doReset();
        setIn(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h700, 32'h0);
        repeat (3) tick();
        chk("fair.dataDone", 32'(dm_ready), 32'd1);
        setIn(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        setIn(1'b1, 1'b1, 32'h800, 1'b1, 1'b0, 32'h700, 32'h0);
        tick();
        chk("fair.fetchAfterData.en", 32'(mem_en), 32'd1);
        chk("fair.fetchAfterData.addr", mem_addr, 32'h800);

        // Enable low for 4 cycles mid-access delays ready by exactly 4 cycles
        doReset();
        setIn(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h500, 32'h0);
        tick();
        chk("freeze.grantEn", 32'(mem_en), 32'd1);
        chk("freeze.grantAddr", mem_addr, 32'h500);
        for (int c = 0; c < 4; c++) begin
            setIn(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h500, 32'h0);
            tick();
            chk($sformatf("freeze%0d.mem_en", c), 32'(mem_en), 32'd1);
            chk($sformatf("freeze%0d.mem_addr", c), mem_addr, 32'h500);
            chk($sformatf("freeze%0d.dm_ready", c), 32'(dm_ready), 32'd0);
        end
        setIn(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h500, 32'h0);
        begin
            int k = 0;
            while (!dm_ready && k < 10) begin
                tick();
                k++;
            end
            chk("freeze.resumeCycles", 32'(k), 32'd2);
        end
        chk("freeze.dm_rdata", dm_rdata, 32'hFFFFFAFF);

        // Reset dropped in the second strobe cycle of a data read
        doReset();
        setIn(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h600, 32'h0);
        tick();
        chk("rstMid.cycle1En", 32'(mem_en), 32'd1);
        tick();
        #2 reset = 1'b0;
        #1;
        chk("rstMid.asyncEn", 32'(mem_en), 32'd0);
        chk("rstMid.asyncRdy", 32'(dm_ready), 32'd0);
        tick();
        chk("rstMid.heldEn", 32'(mem_en), 32'd0);
        chk("rstMid.heldRdy", 32'(dm_ready), 32'd0);
        reset = 1'b1;
        begin
            int k = 0;
            while (!dm_ready && k < 8) begin
                tick();
                k++;
            end
            chk("rstMid.regrantLatency", 32'(k), 32'd3);
        end
        chk("rstMid.dm_rdata", dm_rdata, 32'hFFFFF9FF);

        // Randomized requesters obeying the hold-until-ready protocol
        doReset();
        for (int c = 0; c < 3000; c++) begin
            if (ifPend && mIfReady) ifPend = 1'b0;
            else if (ifPend && !(mBusy && !mPortData) && $urandom_range(0, 19) == 0) ifPend = 1'b0;
            if (!ifPend) begin
                ifA = $urandom;
                if ($urandom_range(0, 2) == 0) ifPend = 1'b1;
            end
            if (dmPend && mDmReady) dmPend = 1'b0;
            else if (dmPend && !(mBusy && mPortData) && $urandom_range(0, 19) == 0) dmPend = 1'b0;
            if (!dmPend) begin
                dmA = $urandom;
                dmD = $urandom;
                dmWeV = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 2) == 0) dmPend = 1'b1;
            end
            setIn(1'($urandom_range(0, 7) != 0), ifPend, ifA, dmPend, dmWeV, dmA, dmD);
            tick();
            checkModel($sformatf("rand%0d", c));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end
endmodule
